// File: rtl/pixel_sched_pkg.sv
// Shared types and helpers for the pixel window scheduler.
package pixel_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        ACTIVE,
        DONE
    } state_t;

    function automatic int clog2_safe(input int n);
        int r;
        r = $clog2(n);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pixel_window_scheduler_edge_det.sv
// One-bit registered rising/falling edge detector.
module pixel_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_rise,
    output logic o_fall
);

    logic r_d;

    always_ff @(posedge clk) begin
        if (reset) r_d <= 1'b0;
        else       r_d <= i_d;
    end

    assign o_rise = i_d & ~r_d;
    assign o_fall = ~i_d & r_d;

endmodule

// File: rtl/pixel_window_scheduler.sv
// Column/row tracking, line-buffer rotation and KxK window flagging from vs/de.
// Optional PIXEL_SCHED_STATS_EN builds the completed-frame counter on frame_cnt.
module pixel_window_scheduler
    import pixel_sched_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int K     = 3,
    parameter int COL_W = clog2_safe(IMG_W),
    parameter int ROW_W = clog2_safe(IMG_H),
    parameter int SEL_W = clog2_safe(K)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             vs_in,
    input  logic             hs_in,
    input  logic             de_in,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             lb_wr_en,
    output logic [COL_W-1:0] lb_wr_addr,
    output logic [SEL_W-1:0] lb_sel,
    output logic             win_valid,
    output logic             sof,
    output logic             eol,
    output logic             eof,
    output logic             line_err,
    output logic             ovf_err,
    output logic [15:0]      frame_cnt
);

    localparam int CNT_W = COL_W + 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(IMG_W);
    localparam logic [COL_W-1:0] COL_WIN  = COL_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_WIN  = ROW_W'(K - 1);

    logic w_vs_rise, w_vs_fall, w_de_rise, w_de_fall;
    logic w_unused;

    pixel_edge_det u_vs_edge (
        .clk   (clk),
        .reset (reset),
        .i_d   (vs_in),
        .o_rise(w_vs_rise),
        .o_fall(w_vs_fall)
    );

    pixel_edge_det u_de_edge (
        .clk   (clk),
        .reset (reset),
        .i_d   (de_in),
        .o_rise(w_de_rise),
        .o_fall(w_de_fall)
    );

    assign w_unused = ^{w_vs_fall, w_de_rise, hs_in};

    state_t           r_state, w_state_nx;
    logic [COL_W-1:0] r_col, w_col_nx;
    logic [ROW_W-1:0] r_row, w_row_nx;
    logic [SEL_W-1:0] r_sel, w_sel_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             r_line_err, w_line_err_nx;
    logic             r_ovf_err, w_ovf_err_nx;
    logic             r_wr_en, r_win, r_sof, r_eol, r_eof;
    logic             w_wr, w_win, w_sof, w_eol, w_eof;

    always_comb begin
        w_state_nx    = r_state;
        w_col_nx      = r_col;
        w_row_nx      = r_row;
        w_sel_nx      = r_sel;
        w_cnt_nx      = r_cnt;
        w_line_err_nx = r_line_err;
        w_ovf_err_nx  = r_ovf_err;
        w_wr          = 1'b0;

        // A vs edge overrides everything; a coincident de pixel becomes col 0 of the new frame.
        if (w_vs_rise) begin
            w_col_nx = '0;
            w_row_nx = '0;
            w_sel_nx = '0;
            w_cnt_nx = '0;
            if (r_state == WAIT_LINE || r_state == ACTIVE) begin
                w_line_err_nx = 1'b1;
            end else begin
                w_line_err_nx = 1'b0;
                w_ovf_err_nx  = 1'b0;
            end
            if (de_in) begin
                w_wr       = 1'b1;
                w_cnt_nx   = CNT_W'(1);
                w_state_nx = ACTIVE;
            end else begin
                w_state_nx = WAIT_LINE;
            end
        end else begin
            case (r_state)
                WAIT_LINE: begin
                    if (de_in) begin
                        w_wr       = 1'b1;
                        w_col_nx   = '0;
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (de_in) begin
                        if (r_cnt < CNT_FULL) begin
                            w_wr     = 1'b1;
                            w_col_nx = r_cnt[COL_W-1:0];
                            w_cnt_nx = r_cnt + 1'b1;
                        end else begin
                            w_line_err_nx = 1'b1;
                        end
                    end else if (w_de_fall) begin
                        if (r_cnt != CNT_FULL) w_line_err_nx = 1'b1;
                        w_col_nx = '0;
                        w_cnt_nx = '0;
                        w_sel_nx = (r_sel == SEL_LAST) ? '0 : r_sel + 1'b1;
                        // Row holds at the last line so it never exceeds IMG_H-1.
                        if (r_row == ROW_LAST) begin
                            w_state_nx = DONE;
                        end else begin
                            w_row_nx   = r_row + 1'b1;
                            w_state_nx = WAIT_LINE;
                        end
                    end
                end
                DONE: begin
                    if (de_in) w_ovf_err_nx = 1'b1;
                end
                default: ;
            endcase
        end

        w_win = w_wr && (w_row_nx >= ROW_WIN) && (w_col_nx >= COL_WIN);
        w_sof = w_wr && (w_row_nx == '0) && (w_col_nx == '0);
        w_eol = w_wr && (w_col_nx == COL_LAST);
        w_eof = w_eol && (w_row_nx == ROW_LAST);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_col      <= '0;
            r_row      <= '0;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_line_err <= 1'b0;
            r_ovf_err  <= 1'b0;
            r_wr_en    <= 1'b0;
            r_win      <= 1'b0;
            r_sof      <= 1'b0;
            r_eol      <= 1'b0;
            r_eof      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_col      <= w_col_nx;
            r_row      <= w_row_nx;
            r_sel      <= w_sel_nx;
            r_cnt      <= w_cnt_nx;
            r_line_err <= w_line_err_nx;
            r_ovf_err  <= w_ovf_err_nx;
            r_wr_en    <= w_wr;
            r_win      <= w_win;
            r_sof      <= w_sof;
            r_eol      <= w_eol;
            r_eof      <= w_eof;
        end
    end

    assign col        = r_col;
    assign lb_wr_addr = r_col;
    assign row        = r_row;
    assign lb_sel     = r_sel;
    assign lb_wr_en   = r_wr_en;
    assign win_valid  = r_win;
    assign sof        = r_sof;
    assign eol        = r_eol;
    assign eof        = r_eof;
    assign line_err   = r_line_err;
    assign ovf_err    = r_ovf_err;

`ifdef PIXEL_SCHED_STATS_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset)      r_frame_cnt <= '0;
        else if (w_eof) r_frame_cnt <= r_frame_cnt + 16'd1;
    end

    assign frame_cnt = r_frame_cnt;
`else
    assign frame_cnt = '0;
`endif

endmodule
